// File: rtl/counter_readout_pkg.sv
// counter_readout_pkg: shared constants, state type and header layout for counter_readout
package counter_readout_pkg;
  localparam logic [7:0] HDR_MAGIC = 8'hA5;
  localparam int FRAME_WORDS = 5;
  localparam int HDR_MAGIC_POS = 24;
  localparam int HDR_SEQ_POS = 16;
  localparam int HDR_DROP_POS = 8;
  localparam int HDR_LEN_POS = 0;
  typedef enum logic {IDLE, SEND} state_t;
  function automatic logic [31:0] make_hdr(input logic [7:0] seq, input logic [7:0] drop);
    logic [31:0] h;
    h = '0;
    h[HDR_MAGIC_POS +: 8] = HDR_MAGIC;
    h[HDR_SEQ_POS +: 8] = seq;
    h[HDR_DROP_POS +: 8] = drop;
    h[HDR_LEN_POS +: 8] = 8'(FRAME_WORDS);
    return h;
  endfunction
endpackage

// File: rtl/counter_readout_if.sv
// counter_readout_if: valid/ready word stream carrying readout frames
interface counter_readout_if #(parameter int W = 32) ();
  logic Valid;
  logic Ready;
  logic Last;
  logic [W-1:0] DataOut;
  modport master (output Valid, output Last, output DataOut, input Ready);
  modport slave (input Valid, input Last, input DataOut, output Ready);
endinterface

// File: rtl/sat_counter.sv
// sat_counter: saturating up-counter with synchronous clear
module sat_counter #(parameter int W = 8) (
  input  logic         Clk,
  input  logic         Reset,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] q
);
  always_ff @(posedge Clk)
    q <= (Reset || clr) ? '0 : (inc && !(&q)) ? q + W'(1) : q;
endmodule

// File: rtl/counter_readout.sv
// counter_readout: snapshots two counters on Capture and streams them as a five-word framed packet
module counter_readout
  import counter_readout_pkg::*;
#(
  parameter int CNT_W = 64,
  parameter int OUT_W = 32
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic [CNT_W-1:0] Cnt0,
  input  logic [CNT_W-1:0] Cnt1,
  input  logic             Capture,
  output logic             Busy,
  counter_readout_if.master bus
);
  state_t state;
  logic [2:0] idx;
  logic [7:0] seq, hdr_drop, drop_cnt;
  logic [CNT_W-1:0] snap0, snap1;
  logic [OUT_W-1:0] word;
  logic last;
  // a Capture that arrives while a frame is in flight is only counted
  sat_counter #(.W(8)) drops (
    .Clk(Clk),
    .Reset(Reset),
    .clr(state == IDLE && Capture),
    .inc(state == SEND && Capture),
    .q(drop_cnt)
  );
  always_ff @(posedge Clk)
    if (Reset) begin
      state <= IDLE;
      idx <= '0;
      seq <= '0;
      hdr_drop <= '0;
      snap0 <= '0;
      snap1 <= '0;
    end else if (state == IDLE) begin
      if (Capture) begin
        snap0 <= Cnt0;
        snap1 <= Cnt1;
        hdr_drop <= drop_cnt;
        idx <= '0;
        state <= SEND;
      end
    end else if (bus.Ready) begin
      if (last) begin
        state <= IDLE;
        seq <= seq + 8'd1;
      end else
        idx <= idx + 3'd1;
    end
  always_comb begin
    Busy = state == SEND;
    last = Busy && idx == 3'(FRAME_WORDS - 1);
    word = idx == 3'd0 ? OUT_W'(make_hdr(seq, hdr_drop)) :
           idx == 3'd1 ? snap0[OUT_W-1:0] :
           idx == 3'd2 ? snap0[CNT_W-1:OUT_W] :
           idx == 3'd3 ? snap1[OUT_W-1:0] : snap1[CNT_W-1:OUT_W];
    bus.Valid = Busy;
    bus.Last = last;
    bus.DataOut = Busy ? word : '0;
  end
endmodule

// File: tb/tb_counter_readout.sv
// tb_counter_readout: randomized frame-level checks of counter_readout against a packet model
module tb_counter_readout;
  logic Clk, Reset, Capture, Busy;
  logic [63:0] Cnt0, Cnt1;
  int compared = 0, mismatched = 0;
  logic [7:0] m_seq, m_drop;
  counter_readout_if #(.W(32)) bus ();
  counter_readout #(.CNT_W(64), .OUT_W(32)) dut (
    .Clk(Clk), .Reset(Reset), .Cnt0(Cnt0), .Cnt1(Cnt1),
    .Capture(Capture), .Busy(Busy), .bus(bus)
  );
  initial begin
    Clk = 0;
    forever #5 Clk = ~Clk;
  end

  task automatic check_idle(input string name);
    compared++;
    if ({bus.Valid, bus.Last, Busy, bus.DataOut} !== 35'd0) begin
      mismatched++;
      $display("FAIL %s: v=%b l=%b busy=%b d=%h, want all zero", name, bus.Valid, bus.Last, Busy, bus.DataOut);
    end
  endtask

  // one frame: capture c0/c1, then track the expected words through random stalls and drops
  task automatic send_frame(input logic [63:0] c0, input logic [63:0] c1, input int stall_pct,
                            input int stall_w2, input int cap_pct, input bit cap_last);
    logic [31:0] exp [5];
    int k, cyc, held;
    k = 0; cyc = 0; held = 0;
    exp[0] = {8'hA5, m_seq, m_drop, 8'h05};
    exp[1] = c0[31:0];
    exp[2] = c0[63:32];
    exp[3] = c1[31:0];
    exp[4] = c1[63:32];
    m_drop = 0;
    Cnt0 = c0; Cnt1 = c1; Capture = 1; bus.Ready = 1'($urandom);
    @(negedge Clk);
    while (k < 5 && cyc < 5000) begin
      Cnt0 = {$urandom, $urandom};
      Cnt1 = {$urandom, $urandom};
      compared++;
      if ({bus.Valid, bus.Last, Busy, bus.DataOut} !== {1'b1, k == 4, 1'b1, exp[k]}) begin
        mismatched++;
        $display("FAIL word%0d: v=%b l=%b busy=%b d=%h, want v=1 l=%b busy=1 d=%h",
                 k, bus.Valid, bus.Last, Busy, bus.DataOut, k == 4, exp[k]);
      end
      if (k == 2 && held < stall_w2) begin
        bus.Ready = 0;
        held++;
      end else
        bus.Ready = $urandom_range(99) >= stall_pct;
      Capture = ($urandom_range(99) < cap_pct) || (cap_last && k == 4 && bus.Ready);
      if (Capture && m_drop != 8'hFF) m_drop++;
      @(negedge Clk);
      if (bus.Ready) k++;
      cyc++;
    end
    Capture = 0;
    bus.Ready = 1'($urandom);
    if (k < 5) begin
      compared++;
      mismatched++;
      $display("FAIL frame_timeout: words sent %0d, want 5", k);
    end
    check_idle("after_frame");
    m_seq++;
  endtask

  task automatic test_reset;
    Reset = 1; Capture = 0; bus.Ready = 0; Cnt0 = '0; Cnt1 = '0;
    repeat (3) @(negedge Clk);
    check_idle("reset");
    Reset = 0;
    m_seq = 0; m_drop = 0;
    @(negedge Clk);
    check_idle("post_reset");
  endtask

  task automatic test_basic;
    send_frame(64'h0000_0001_0000_0002, 64'h0000_0000_0000_0003, 0, 0, 0, 0);
  endtask

  task automatic test_backpressure;
    send_frame({$urandom, $urandom}, {$urandom, $urandom}, 0, 3, 0, 0);
    send_frame({$urandom, $urandom}, {$urandom, $urandom}, 40, 3, 0, 0);
  endtask

  task automatic test_drops;
    send_frame({$urandom, $urandom}, {$urandom, $urandom}, 30, 2, 25, 1);
    send_frame({$urandom, $urandom}, {$urandom, $urandom}, 0, 0, 0, 0);
  endtask

  task automatic test_saturation;
    send_frame({$urandom, $urandom}, {$urandom, $urandom}, 0, 300, 100, 1);
    send_frame({$urandom, $urandom}, {$urandom, $urandom}, 0, 0, 0, 0);
  endtask

  task automatic test_seq_wrap;
    for (int i = 0; i < 258; i++)
      send_frame({$urandom, $urandom}, {$urandom, $urandom}, 20, 0, 10, i[0]);
  endtask

  task automatic test_reset_mid;
    Cnt0 = {$urandom, $urandom}; Cnt1 = {$urandom, $urandom};
    Capture = 1; bus.Ready = 1;
    @(negedge Clk);
    Capture = 0;
    repeat (2) @(negedge Clk);
    Reset = 1;
    @(negedge Clk);
    check_idle("reset_mid");
    Reset = 0;
    m_seq = 0; m_drop = 0;
    @(negedge Clk);
    check_idle("reset_mid_idle");
    send_frame({$urandom, $urandom}, {$urandom, $urandom}, 0, 0, 0, 0);
    send_frame({$urandom, $urandom}, {$urandom, $urandom}, 30, 1, 20, 1);
  endtask

  initial begin
    Reset = 1; Capture = 0; Cnt0 = '0; Cnt1 = '0; bus.Ready = 0;
    m_seq = 0; m_drop = 0;
    @(negedge Clk);
    test_reset;
    test_basic;
    test_backpressure;
    test_drops;
    test_saturation;
    test_seq_wrap;
    test_reset_mid;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule

// File: doc/counter_readout.md
# counter_readout

Downstream stage of the dual event counter. On a `Capture` pulse it snapshots both 64-bit counter values in the same cycle and streams them out as a five-word, 32-bit framed packet over a valid/ready handshake. This lets a narrow host bus or trace sink read coherent counter pairs without stalling the counter.

## Interface
Parameters:
- `CNT_W`, default 64: counter width. Fixed at 2*`OUT_W`.
- `OUT_W`, default 32: output word width.

Ports:
- `Clk`  in  1  clock; all logic is on the rising edge.
- `Reset`  in  1  reset for `Clk`: synchronous, active-high.
- `Cnt0`  in  `CNT_W`  counter 0 value (upstream `Output0`).
- `Cnt1`  in  `CNT_W`  counter 1 value (upstream `Output1`).
- `Capture`  in  1  snapshot request, sampled every cycle.
- `Ready`  in  1  sink accepts the current word.
- `Valid`  out  1  `DataOut` holds a word.
- `DataOut`  out  `OUT_W`  frame word.
- `Last`  out  1  high together with word 4 of the frame.
- `Busy`  out  1  a frame is in flight (state is not IDLE).

## Operation
- FSM states: IDLE and SEND. A 3-bit word index `Idx` runs 0..4.
- **IDLE, `Capture`=1:**
  - latch `Snap0`<=`Cnt0` and `Snap1`<=`Cnt1`
  - latch `HdrDrop`<=`DropCnt`, then clear `DropCnt`
  - `Idx`<=0, go to SEND
- **SEND:**
  - `Valid`=1.
  - `DataOut` is selected by `Idx`:
    - 0: header {8'hA5, `Seq`[7:0], `HdrDrop`[7:0], 8'h05}
    - 1: `Snap0`[31:0]
    - 2: `Snap0`[63:32]
    - 3: `Snap1`[31:0]
    - 4: `Snap1`[63:32]
  - `Last`=(`Idx`==4).
- **Handshake:** a word transfers on an edge where `Valid`&&`Ready`.
  - On transfer with `Idx`<4: `Idx` increments.
  - On transfer with `Idx`==4: go to IDLE and `Seq` increments.
- **`Seq`:** 8-bit, wraps 255->0. It counts completed frames only.
- **`Capture` while `Busy`=1:** the request is dropped and `DropCnt` increments, saturating at 255. This includes a `Capture` in the same cycle as the final handshake.
- **Reset (also mid-frame):** the frame is aborted. Next cycle: `Valid`=0, `Last`=0, `Busy`=0, `DataOut`=0, `Seq`=0, `DropCnt`=0, `Snap0`=`Snap1`=0, state IDLE.
- **Output encoding:** all outputs are decoded from registered state and snapshot only. There is no combinational path from `Ready` or `Capture` to any output.

## Timing
- Latency: `Capture` high at edge N in IDLE gives `Valid`=1 with the header during cycle N+1.
- The snapshot is taken at edge N. Counter changes after N do not affect the frame.
- With `Ready` held high the frame occupies exactly 5 cycles. `Busy` falls the cycle after the word-4 transfer.
- Minimum frame-to-frame spacing: 6 cycles, because IDLE must see `Capture`.
- `Ready` low stalls the frame indefinitely. `DataOut`, `Valid` and `Last` must hold stable while stalled.
- `Ready` is ignored while `Valid`=0.

## Structure
- Shared package `counter_readout_pkg` holds:
  - `HDR_MAGIC`=8'hA5
  - `FRAME_WORDS`=5
  - the state enum {IDLE, SEND}
  - the header field positions
- One natural sub-module: `sat_counter` (8-bit, saturating, with synchronous clear) for `DropCnt`.
- `Seq` is a plain wrap counter and stays inline.

## Test plan
- **Basic frame:** `Cnt0`=64'h0000_0001_0000_0002, `Cnt1`=64'h0000_0000_0000_0003, one `Capture` pulse, `Ready`=1.
  - Expect words A5_00_00_05, 00000002, 00000001, 00000003, 00000000 on consecutive cycles.
  - Expect `Last` only on word 5, and `Busy` low on cycle 6.
- **Backpressure:** `Ready` low for 3 cycles on word 2, with `Cnt0` changing meanwhile.
  - Expect `DataOut` and `Valid` held constant through the stall.
  - Expect snapshot values transmitted, not live values.
- **Drops:** 3 extra `Capture` pulses during a frame, including one on the final-handshake cycle.
  - Expect the next frame's header = A5_01_03_05.
  - Expect `DropCnt` cleared afterwards.
- **Saturation and wrap:**
  - 300 drops: expect header drop field = FF.
  - 256 completed frames: expect `Seq` back to 00.
- **Reset mid-frame:** `Reset` asserted during word 3.
  - Expect `Valid`, `Busy` and `Last` all 0 the next cycle.
  - Expect the next frame's header = A5_00_00_05.
